// File: rtl/dual_stream_timing_monitor.sv
// Purpose: in-line timing/protocol monitor for the merged dual-lane pixel stream (line width, frame height, frame count, lane compare).
// Latency: status and sticky flags update one pixclk after the qualifying input edge; o_frame_done is a 1-cycle pulse.
// Backpressure: none; the monitor only observes the stream and never stalls it.
module dual_stream_timing_monitor #(
    parameter int DWIDTH      = 8,
    parameter int CWIDTH      = 12,
    parameter int EXP_WIDTH   = 640,
    parameter int EXP_HEIGHT  = 480,
    parameter int CHECK_LANES = 1
) (
    input  logic                  pixclk,
    input  logic                  rst_n,
    input  logic                  i_image_hs,
    input  logic                  i_image_vs,
    input  logic                  i_image_valid,
    input  logic [2*DWIDTH-1:0]   i_image_data,
    input  logic                  i_clr,
    output logic [CWIDTH-1:0]     o_line_width,
    output logic [CWIDTH-1:0]     o_frame_lines,
    output logic                  o_frame_done,
    output logic [15:0]           o_frame_cnt,
    output logic                  o_width_err,
    output logic                  o_height_err,
    output logic                  o_lane_err,
    output logic                  o_proto_err
);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [CWIDTH-1:0] CNT_MAX = '1;
    localparam logic [CWIDTH-1:0] EXP_W   = CWIDTH'(EXP_WIDTH);
    localparam logic [CWIDTH-1:0] EXP_H   = CWIDTH'(EXP_HEIGHT);

    state_t             state;
    state_t             state_nxt;

    logic               hs_d;
    logic               vs_d;
    logic               line_end;
    logic               frm_start;
    logic               frm_end;

    logic [CWIDTH-1:0]  pix_cnt;
    logic [CWIDTH-1:0]  line_cnt;
    logic [CWIDTH-1:0]  pix_inc;
    logic [CWIDTH-1:0]  line_inc;
    logic [CWIDTH-1:0]  lines_rep;
    logic [CWIDTH-1:0]  valid_ext;

    logic               do_start;
    logic               do_report;
    logic               counting;

    logic               width_evt;
    logic               height_evt;
    logic               lane_evt;
    logic               proto_evt;

    // Edge strobes: compare current inputs against last cycle's registered copies.
    assign line_end  = hs_d & ~i_image_hs;
    assign frm_start = ~vs_d & i_image_vs;
    assign frm_end   = vs_d & ~i_image_vs;

    assign valid_ext = {{(CWIDTH-1){1'b0}}, i_image_valid};

    // State register; an async reset always lands in SYNC so a frame cut by reset is never reported.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the per-cycle action strobes that drive the datapath.
    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_report = 1'b0;
        counting  = 1'b0;
        case (state)
            SYNC: begin
                // Only start measuring once vs has been seen low, so the first frame is whole.
                if (!i_image_vs) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (frm_start) begin
                    state_nxt = ACTIVE;
                    do_start  = 1'b1;
                end
            end
            ACTIVE: begin
                counting = 1'b1;
                if (frm_end) begin
                    state_nxt = IDLE;
                    do_report = 1'b1;
                end
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

    // Saturating counter increments, the frame height to report, and the error events.
    always_comb begin
        pix_inc    = (pix_cnt == CNT_MAX) ? pix_cnt : pix_cnt + valid_ext;
        line_inc   = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + 1'b1;
        // A line ending in the same cycle as the frame belongs to this frame.
        lines_rep  = line_end ? line_inc : line_cnt;
        width_evt  = counting & line_end & (pix_cnt != EXP_W);
        height_evt = do_report & (lines_rep != EXP_H);
        lane_evt   = (CHECK_LANES != 0) & (state != SYNC) & i_image_valid &
                     (i_image_data[2*DWIDTH-1:DWIDTH] != i_image_data[DWIDTH-1:0]);
        proto_evt  = (state == IDLE) & (i_image_valid | i_image_hs) & ~i_image_vs;
    end

    // Edge-detect registers and the pixel/line counters.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d     <= 1'b0;
            vs_d     <= 1'b0;
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else begin
            hs_d <= i_image_hs;
            vs_d <= i_image_vs;
            if (do_start) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
            end else if (counting) begin
                if (line_end) begin
                    line_cnt <= line_inc;
                    // A pixel on the hs-low cycle opens the next line (zero-gap lines).
                    pix_cnt  <= valid_ext;
                end else begin
                    pix_cnt  <= pix_inc;
                end
            end
        end
    end

    // Registered status: last line width, last frame height, done pulse and frame counter.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            o_line_width  <= '0;
            o_frame_lines <= '0;
            o_frame_done  <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            o_frame_done <= do_report;
            if (counting && line_end) begin
                o_line_width <= pix_cnt;
            end
            if (do_report) begin
                o_frame_lines <= lines_rep;
            end
            // Clear wins over the old count but a frame finishing in the same cycle still counts.
            if (i_clr) begin
                o_frame_cnt <= {15'd0, do_report};
            end else if (do_report) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
        end
    end

    // Sticky error flags: an event in the same cycle as i_clr leaves the flag set.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            o_width_err  <= 1'b0;
            o_height_err <= 1'b0;
            o_lane_err   <= 1'b0;
            o_proto_err  <= 1'b0;
        end else begin
            o_width_err  <= (o_width_err  & ~i_clr) | width_evt;
            o_height_err <= (o_height_err & ~i_clr) | height_evt;
            o_lane_err   <= (o_lane_err   & ~i_clr) | lane_evt;
            o_proto_err  <= (o_proto_err  & ~i_clr) | proto_evt;
        end
    end

endmodule

// File: tb/tb_dual_stream_timing_monitor.sv
// Purpose: self-checking bench for dual_stream_timing_monitor with a line-width / frame-report scoreboard.
// Latency: expects line width one cycle after hs falls and the frame report one cycle after vs falls.
// Backpressure: not applicable; the stream is driven open-loop.
module tb_dual_stream_timing_monitor;

    logic        pixclk = 1'b0;
    logic        rst_n;
    logic        i_image_hs;
    logic        i_image_vs;
    logic        i_image_valid;
    logic [15:0] i_image_data;
    logic        i_clr;

    logic [11:0] o_line_width;
    logic [11:0] o_frame_lines;
    logic        o_frame_done;
    logic [15:0] o_frame_cnt;
    logic        o_width_err;
    logic        o_height_err;
    logic        o_lane_err;
    logic        o_proto_err;

    logic [11:0] b_line_width;
    logic [11:0] b_frame_lines;
    logic        b_frame_done;
    logic [15:0] b_frame_cnt;
    logic        b_width_err;
    logic        b_height_err;
    logic        b_lane_err;
    logic        b_proto_err;

    typedef struct {
        int          lines;
        logic [15:0] cnt;
    } frame_exp_t;

    int          wq[$];
    frame_exp_t  fq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_cnt  = 16'd0;
    logic        hs_q     = 1'b0;
    logic        le_seen  = 1'b0;

    dual_stream_timing_monitor #(
        .DWIDTH(8), .CWIDTH(12), .EXP_WIDTH(16), .EXP_HEIGHT(4), .CHECK_LANES(1)
    ) dut (
        .pixclk(pixclk), .rst_n(rst_n),
        .i_image_hs(i_image_hs), .i_image_vs(i_image_vs),
        .i_image_valid(i_image_valid), .i_image_data(i_image_data), .i_clr(i_clr),
        .o_line_width(o_line_width), .o_frame_lines(o_frame_lines),
        .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt),
        .o_width_err(o_width_err), .o_height_err(o_height_err),
        .o_lane_err(o_lane_err), .o_proto_err(o_proto_err)
    );

    dual_stream_timing_monitor #(
        .DWIDTH(8), .CWIDTH(12), .EXP_WIDTH(16), .EXP_HEIGHT(4), .CHECK_LANES(0)
    ) dut_nolane (
        .pixclk(pixclk), .rst_n(rst_n),
        .i_image_hs(i_image_hs), .i_image_vs(i_image_vs),
        .i_image_valid(i_image_valid), .i_image_data(i_image_data), .i_clr(i_clr),
        .o_line_width(b_line_width), .o_frame_lines(b_frame_lines),
        .o_frame_done(b_frame_done), .o_frame_cnt(b_frame_cnt),
        .o_width_err(b_width_err), .o_height_err(b_height_err),
        .o_lane_err(b_lane_err), .o_proto_err(b_proto_err)
    );

    always #5 pixclk = ~pixclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stream inputs; they are sampled at the next posedge.
    task automatic cyc(input logic vs_v, input logic hs_v, input logic va_v, input logic [15:0] d);
        i_image_vs    = vs_v;
        i_image_hs    = hs_v;
        i_image_valid = va_v;
        i_image_data  = d;
        @(posedge pixclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic clr_pulse();
        i_clr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        i_clr = 1'b0;
        exp_cnt = 16'd0;
        idle(1);
    endtask

    task automatic check_errs(input string tag, input logic w, input logic h, input logic l, input logic p);
        chk({tag, "_width_err"},  {31'd0, o_width_err},  {31'd0, w});
        chk({tag, "_height_err"}, {31'd0, o_height_err}, {31'd0, h});
        chk({tag, "_lane_err"},   {31'd0, o_lane_err},   {31'd0, l});
        chk({tag, "_proto_err"},  {31'd0, o_proto_err},  {31'd0, p});
    endtask

    // One frame of 16-pixel lines; short_idx picks a 15-pixel line, sim_end drops vs with the last hs.
    task automatic send_frame(input int nlines, input int short_idx, input bit sim_end,
                              input bit bad_lane, input bit clr_end);
        int          w;
        logic [7:0]  p;
        logic [15:0] d;
        frame_exp_t  fe;
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int l = 0; l < nlines; l++) begin
            w = (l == short_idx) ? 15 : 16;
            wq.push_back(w);
            for (int k = 0; k < w; k++) begin
                p = 8'($urandom);
                d = (bad_lane && l == 0 && k == 0) ? 16'h1234 : {p, p};
                cyc(1'b1, 1'b1, 1'b1, d);
            end
            if (!(sim_end && l == nlines - 1)) begin
                cyc(1'b1, 1'b0, 1'b0, 16'h0000);
                cyc(1'b1, 1'b0, 1'b0, 16'h0000);
            end
        end
        exp_cnt  = clr_end ? 16'd1 : exp_cnt + 16'd1;
        fe.lines = nlines;
        fe.cnt   = exp_cnt;
        fq.push_back(fe);
        i_clr = clr_end;
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        i_clr = 1'b0;
        idle(2);
    endtask

    // Line-end tracker mirroring what the monitor should see on each posedge.
    always @(posedge pixclk) begin
        le_seen <= rst_n && hs_q && !i_image_hs;
        hs_q    <= rst_n ? i_image_hs : 1'b0;
    end

    // Scoreboard: pop expected widths on each line end, expected frame reports on each done pulse.
    always @(negedge pixclk) begin
        if (le_seen && wq.size() > 0) begin
            chk("line_width", {20'd0, o_line_width}, wq.pop_front());
        end
        if (o_frame_done) begin
            if (fq.size() == 0) begin
                chk("unexpected_done", {31'd0, o_frame_done}, 32'd0);
            end else begin
                frame_exp_t fe;
                fe = fq.pop_front();
                chk("frame_lines", {20'd0, o_frame_lines}, fe.lines);
                chk("frame_cnt",   {16'd0, o_frame_cnt},   {16'd0, fe.cnt});
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        i_clr         = 1'b0;
        i_image_vs    = 1'b0;
        i_image_hs    = 1'b0;
        i_image_valid = 1'b0;
        i_image_data  = 16'h0000;
        repeat (3) @(posedge pixclk);
        #1;
        chk("rst_line_width",  {20'd0, o_line_width},  32'd0);
        chk("rst_frame_lines", {20'd0, o_frame_lines}, 32'd0);
        chk("rst_frame_done",  {31'd0, o_frame_done},  32'd0);
        chk("rst_frame_cnt",   {16'd0, o_frame_cnt},   32'd0);
        check_errs("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(3);

        // T1: two clean frames
        send_frame(4, -1, 0, 0, 0);
        send_frame(4, -1, 0, 0, 0);
        chk("t1_frame_cnt",   {16'd0, o_frame_cnt},   32'd2);
        chk("t1_line_width",  {20'd0, o_line_width},  32'd16);
        chk("t1_frame_lines", {20'd0, o_frame_lines}, 32'd4);
        check_errs("t1", 1'b0, 1'b0, 1'b0, 1'b0);

        // T2: third line short by one pixel
        send_frame(4, 2, 0, 0, 0);
        check_errs("t2", 1'b1, 1'b0, 1'b0, 1'b0);
        clr_pulse();
        check_errs("t2_clr", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_clr_cnt", {16'd0, o_frame_cnt}, 32'd0);

        // T3: three-line frame
        send_frame(3, -1, 0, 0, 0);
        check_errs("t3", 1'b0, 1'b1, 1'b0, 1'b0);
        clr_pulse();
        check_errs("t3_clr", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_clr_cnt", {16'd0, o_frame_cnt}, 32'd0);

        // T4: one mismatched-lane pixel; the lane-check-disabled instance must stay quiet
        send_frame(4, -1, 0, 1, 0);
        check_errs("t4", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_nolane_lane_err", {31'd0, b_lane_err}, 32'd0);
        clr_pulse();

        // Protocol: valid while vs low in IDLE
        cyc(1'b0, 1'b0, 1'b1, 16'h5555);
        idle(1);
        check_errs("proto", 1'b0, 1'b0, 1'b0, 1'b1);
        clr_pulse();
        check_errs("proto_clr", 1'b0, 1'b0, 1'b0, 1'b0);

        // T5: vs falls with the last hs, clear coinciding with frame end
        send_frame(4, -1, 1, 0, 1);
        check_errs("t5", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_frame_cnt", {16'd0, o_frame_cnt}, 32'd1);

        // Short last line ending with vs, clear coinciding with the width error
        send_frame(4, 3, 1, 0, 1);
        check_errs("t7", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t7_frame_cnt", {16'd0, o_frame_cnt}, 32'd1);
        clr_pulse();

        // T6: reset in the middle of line 2, released while vs is high
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 1'b1, 16'h0707);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b1, 16'h0909);
        rst_n = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 16'h0909);
        cyc(1'b1, 1'b1, 1'b1, 16'h0909);
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b1, 16'h0909);
        for (int l = 0; l < 2; l++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0000);
            cyc(1'b1, 1'b0, 1'b0, 16'h0000);
            for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 1'b1, 16'h0a0a);
        end
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        idle(3);
        chk("t6_no_done_cnt", {16'd0, o_frame_cnt}, 32'd0);
        send_frame(4, -1, 0, 0, 0);
        chk("t6_frame_cnt",   {16'd0, o_frame_cnt},   32'd1);
        chk("t6_line_width",  {20'd0, o_line_width},  32'd16);
        chk("t6_frame_lines", {20'd0, o_frame_lines}, 32'd4);
        check_errs("t6", 1'b0, 1'b0, 1'b0, 1'b0);

        idle(4);
        chk("width_queue_left", wq.size(), 32'd0);
        chk("frame_queue_left", fq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
